// File: rtl/status_reg_stack.sv
// Processor status register with a hardware save/restore stack for interrupt entry/return.
// Optional sticky overflow/underflow error flags are built when STATUS_STACK_ERR_EN is defined.
module status_reg_stack #(
    parameter int               WIDTH         = 8,
    parameter int               DEPTH         = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE   = 8'h04,
    parameter logic [WIDTH-1:0] WRITE_MASK    = 8'hEF,
    parameter int               B_BIT         = 4,
    parameter logic [WIDTH-1:0] PUSH_SET_MASK = 8'h04
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_en,
    input  logic [WIDTH-1:0]           bus_din,
    input  logic                       bus_wr,
    input  logic                       bus_rd,
    output logic [WIDTH-1:0]           bus_dout,
    output logic                       bus_oe,
    input  logic [WIDTH-1:0]           alu_flags,
    input  logic [WIDTH-1:0]           upd_mask,
    input  logic                       brk_in,
    input  logic                       push,
    input  logic                       pop,
    output logic [WIDTH-1:0]           flags_out,
    output logic [$clog2(DEPTH):0]     depth_cnt,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       err_ovf,
    output logic                       err_unf
);

    localparam int               AW         = $clog2(DEPTH);
    localparam int               DW         = AW + 1;
    localparam logic [WIDTH-1:0] B_MASK     = {{(WIDTH-1){1'b0}}, 1'b1} << B_BIT;
    localparam logic [DW-1:0]    DEPTH_ONE  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]    DEPTH_FULL = DW'(DEPTH);

    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_BUS_WR = 3'd1,
        OP_SWAP   = 3'd2,
        OP_PUSH   = 3'd3,
        OP_OVF    = 3'd4,
        OP_POP    = 3'd5,
        OP_UNF    = 3'd6
    } op_t;

    function automatic logic [WIDTH-1:0] make_image(input logic [WIDTH-1:0] f, input logic b);
        logic [WIDTH-1:0] img;
        img        = f;
        img[B_BIT] = b;
        return img;
    endfunction

    function automatic logic [WIDTH-1:0] clear_b(input logic [WIDTH-1:0] f);
        return f & ~B_MASK;
    endfunction

    logic [WIDTH-1:0] flags_r;
    logic [DW-1:0]    depth_r;
    logic             full_r;
    logic             empty_r;
    logic [WIDTH-1:0] stack_mem_r [DEPTH];

    op_t              op_s;
    logic [WIDTH-1:0] image_s;
    logic [WIDTH-1:0] flags_nxt_s;
    logic [WIDTH-1:0] wr_mask_s;
    logic [DW-1:0]    depth_nxt_s;
    logic [AW-1:0]    top_idx_s;
    logic             stk_we_s;
    logic [AW-1:0]    stk_waddr_s;

    assign image_s     = make_image(flags_r, brk_in);
    assign top_idx_s   = AW'(depth_r - DEPTH_ONE);
    assign wr_mask_s   = upd_mask & WRITE_MASK;
    assign bus_oe      = bus_rd & ~bus_wr;
    assign bus_dout    = bus_oe ? image_s : {WIDTH{1'b0}};
    assign flags_out   = flags_r;
    assign depth_cnt   = depth_r;
    assign stack_full  = full_r;
    assign stack_empty = empty_r;

    // Decode the winning operation for this cycle in priority order.
    always_comb begin
        op_s = OP_ALU;
        if (push && pop && !empty_r) begin
            op_s = OP_SWAP;
        end else if (push && !full_r) begin
            op_s = OP_PUSH;
        end else if (push) begin
            op_s = OP_OVF;
        end else if (pop && !empty_r) begin
            op_s = OP_POP;
        end else if (pop) begin
            op_s = OP_UNF;
        end else if (bus_wr && !bus_rd) begin
            op_s = OP_BUS_WR;
        end else begin
            op_s = OP_ALU;
        end
    end

    // Next flags, depth and stack write for the decoded operation.
    always_comb begin
        flags_nxt_s = flags_r;
        depth_nxt_s = depth_r;
        stk_we_s    = 1'b0;
        stk_waddr_s = top_idx_s;
        case (op_s)
            OP_SWAP: begin
                stk_we_s    = 1'b1;
                stk_waddr_s = top_idx_s;
                flags_nxt_s = clear_b(stack_mem_r[top_idx_s]) | PUSH_SET_MASK;
            end
            OP_PUSH: begin
                stk_we_s    = 1'b1;
                stk_waddr_s = AW'(depth_r);
                flags_nxt_s = flags_r | PUSH_SET_MASK;
                depth_nxt_s = depth_r + DEPTH_ONE;
            end
            OP_POP: begin
                flags_nxt_s = stack_mem_r[top_idx_s];
                depth_nxt_s = depth_r - DEPTH_ONE;
            end
            OP_BUS_WR: begin
                flags_nxt_s = (flags_r & ~wr_mask_s) | (bus_din & wr_mask_s);
            end
            OP_ALU: begin
                flags_nxt_s = (flags_r & ~upd_mask) | (alu_flags & upd_mask);
            end
            default: begin
                flags_nxt_s = flags_r;
                depth_nxt_s = depth_r;
            end
        endcase
    end

    // Live flags, depth and the registered full/empty indicators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_r <= clear_b(RESET_VALUE);
            depth_r <= {DW{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else if (clk_en) begin
            flags_r <= clear_b(flags_nxt_s);
            depth_r <= depth_nxt_s;
            full_r  <= (depth_nxt_s == DEPTH_FULL);
            empty_r <= (depth_nxt_s == {DW{1'b0}});
        end
    end

    // Save-stack storage; contents after reset are irrelevant because depth gates every read.
    always_ff @(posedge clk) begin
        if (clk_en && stk_we_s) begin
            stack_mem_r[stk_waddr_s] <= image_s;
        end
    end

`ifdef STATUS_STACK_ERR_EN
    logic err_ovf_r;
    logic err_unf_r;
    logic err_clr_s;

    assign err_clr_s = (op_s == OP_BUS_WR) && (&bus_din) && empty_r;
    assign err_ovf   = err_ovf_r;
    assign err_unf   = err_unf_r;

    // Sticky error flags; cleared by an all-ones bus write while the stack is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf_r <= 1'b0;
            err_unf_r <= 1'b0;
        end else if (clk_en) begin
            if (op_s == OP_OVF) begin
                err_ovf_r <= 1'b1;
            end else if (err_clr_s) begin
                err_ovf_r <= 1'b0;
            end
            if (op_s == OP_UNF) begin
                err_unf_r <= 1'b1;
            end else if (err_clr_s) begin
                err_unf_r <= 1'b0;
            end
        end
    end
`else
    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
`endif

endmodule

// File: doc/status_reg_stack.md
Name: status_reg_stack

Overview:
- Parametrised processor status register with a hardware save/restore stack for interrupt entry and return.
- Per-bit updates come from the ALU or the data bus, gated by an update mask.
- Push saves the status image and sets the interrupt-disable bits; pop restores the image; up to DEPTH levels nest.
- Sits beside the ALU and the interrupt sequencer; the control unit drives it.

Parameters:
- WIDTH, 8, status register width in bits.
- DEPTH, 4, save-stack entries (power of two, >=2).
- RESET_VALUE, 8'h04, flag state after reset (I bit set, interrupts disabled).
- WRITE_MASK, 8'hEF, bits writable from the bus; other bits are ignored on bus writes.
- B_BIT, 4, bit position of the break indicator; not stored, inserted on read.
- PUSH_SET_MASK, 8'h04, bits forced to 1 in the live register on push.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clk_en  in  1  clock enable; no state changes when low.
- bus_din  in  WIDTH  data-bus write value.
- bus_wr  in  1  bus write request.
- bus_rd  in  1  bus read request.
- bus_dout  out  WIDTH  status image for the bus.
- bus_oe  out  1  bus drive enable (bus_rd & ~bus_wr).
- alu_flags  in  WIDTH  flag results from the ALU.
- upd_mask  in  WIDTH  per-bit update enable.
- brk_in  in  1  break source; appears at B_BIT of the image.
- push  in  1  save image to stack (interrupt entry).
- pop  in  1  restore from stack (return from interrupt).
- flags_out  out  WIDTH  live flags; B_BIT always reads 0.
- depth_cnt  out  $clog2(DEPTH)+1  occupied entries.
- stack_full  out  1  depth_cnt == DEPTH.
- stack_empty  out  1  depth_cnt == 0.
- err_ovf  out  1  sticky push-when-full (optional feature).
- err_unf  out  1  sticky pop-when-empty (optional feature).

Behaviour:
- Reset (async, any time, including mid-push or mid-pop):
  - flags = RESET_VALUE with B_BIT cleared; depth_cnt = 0; stack_empty = 1, stack_full = 0; err_ovf = err_unf = 0.
  - Stack contents are don't-care.
- Status image:
  - image = flags with bit B_BIT replaced by brk_in (combinational).
  - bus_dout = image whenever bus_oe = 1, else 0.
- State changes occur on the rising edge of clk only when clk_en = 1. Latency is 1 cycle; flags_out reflects the update the next cycle.
- Priority per cycle, first match wins:
  1. push & pop, stack not empty (swap):
     - top entry <= image;
     - flags <= old top entry with B_BIT cleared, then OR PUSH_SET_MASK;
     - depth_cnt unchanged.
  2. push & pop, stack empty: behaves as push alone.
  3. push alone, not full:
     - stack[depth_cnt] <= image; depth_cnt += 1;
     - flags <= flags | PUSH_SET_MASK (B_BIT kept 0).
  4. push alone, full: ignored. Flags and depth unchanged; err_ovf set (optional feature).
  5. pop alone, not empty:
     - flags <= stack[depth_cnt-1] with B_BIT cleared; depth_cnt -= 1.
  6. pop alone, empty: ignored; err_unf set (optional feature).
  7. bus_wr & ~bus_rd:
     - for each bit i with upd_mask[i] & WRITE_MASK[i], flags[i] <= bus_din[i];
     - all other bits unchanged.
  8. Neither push nor pop nor bus write: flags <= (flags & ~upd_mask) | (alu_flags & upd_mask).
- In cases 1-6, bus writes and ALU updates in the same cycle are discarded.
- bus_wr & bus_rd together: no write, bus_oe = 0, ALU update per rule 8 still applies.
- Bit B_BIT of flags is never set by any path.
- Stack memory is indexed by depth_cnt; no wrap-around, so entries are never overwritten on overflow.

Optional Feature:
- Macro STATUS_STACK_ERR_EN.
- Defined:
  - err_ovf and err_unf are sticky flags, set on an ignored push or pop;
  - cleared only by rst, or by a bus write with bus_din all ones while stack_empty.
- Undefined: err_ovf and err_unf are tied to 0 and no error logic is built.

Test Plan:
- Reset with WIDTH=8: flags_out=8'h04, depth_cnt=0, stack_empty=1. Then bus_rd=1, brk_in=1 -> bus_dout=8'h14, bus_oe=1.
- ALU update: flags=8'h04, alu_flags=8'hC3, upd_mask=8'hC3 -> next cycle flags_out=8'hC7. Same stimulus with clk_en=0 -> unchanged.
- Bus write: bus_din=8'hFF, upd_mask=8'hFF, bus_wr=1 -> flags_out=8'hEF (B_BIT masked). With bus_rd also high -> no write, bus_oe=0.
- Nesting:
  - flags=8'h01, push -> stack[0]=8'h01, flags=8'h05, depth_cnt=1.
  - Push again -> depth_cnt=2.
  - Pop twice -> flags=8'h05, then flags=8'h01; stack_empty=1.
- Full/empty:
  - 5 pushes at DEPTH=4 -> depth_cnt=4, stack_full=1, 5th push ignored, err_ovf=1 (macro on) or 0 (macro off).
  - Pop on empty stack -> no change, err_unf behaves per macro.
- Swap and reset:
  - Simultaneous push and pop with top=8'h80, flags=8'h41 -> flags=8'h84, top=8'h41, depth unchanged.
  - rst asserted mid-sequence -> immediate reset values.
